// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs a single-outstanding request/response
// handshake with instruction memory. Optional counters are enabled by IF_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] wait_cnt_o
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_drain_addr;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_hold_load;
  logic        w_drain_load;
  logic        w_rsp;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_unused      = ^redirect_pc_i[1:0];
  assign pc4_o         = w_pc_plus4;
  assign w_rsp         = imem_req_o & imem_rvalid_i;

  // Outputs are masked while reset is held so a pending access is never completed.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = r_pc;
    valid_o     = 1'b0;
    instr_o     = NOP_INSTR;
    if (rst_n_i) begin
      case (r_state)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_rvalid_i) begin
            valid_o = 1'b1;
            instr_o = imem_rdata_i;
          end
        end
        S_HOLD: begin
          valid_o = 1'b1;
          instr_o = r_hold_instr;
        end
        S_DRAIN: begin
          imem_req_o  = 1'b1;
          imem_addr_o = r_drain_addr;
        end
        default: ;
      endcase
    end
  end

  // A redirect never abandons an in-flight access: without a response it parks in DRAIN.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_hold_load  = 1'b0;
    w_drain_load = 1'b0;
    if (redirect_i) begin
      w_pc_nxt = w_redirect_pc;
      if ((r_state == S_FETCH) && !w_rsp) begin
        w_state_nxt  = S_DRAIN;
        w_drain_load = 1'b1;
      end else if ((r_state == S_DRAIN) && !w_rsp) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_rsp) begin
            if (stall_i) begin
              w_hold_load = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_pc_nxt = w_pc_plus4;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (w_rsp) w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_hold_instr <= 32'h0000_0000;
      r_drain_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hold_load)  r_hold_instr <= imem_rdata_i;
      if (w_drain_load) r_drain_addr <= r_pc;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_fetch_cnt <= 32'h0000_0000;
      r_wait_cnt  <= 32'h0000_0000;
    end else begin
      if (valid_o && !stall_i && !redirect_i) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == S_FETCH || r_state == S_DRAIN) && !w_rsp)
        r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign wait_cnt_o  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table for the corner cases, then randomized
// traffic against a flag-based model of the fetch behaviour.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] wait_cnt;
`endif

  if_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i (imem_rdata),
    .pc4_o        (pc4),
    .instr_o      (instr),
    .valid_o      (valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt),
    .wait_cnt_o   (wait_cnt)
`endif
  );

  // Instruction memory content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic d, input logic [31:0] p,
                     input logic rv, input logic eq, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redir = d; v.rpc = p; v.rv = rv;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
    vq.push_back(v);
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic        m_held;
  logic [31:0] m_held_word;
  logic        m_discard;
  logic [31:0] m_old_addr;
  logic [31:0] m_fc;
  logic [31:0] m_wc;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_rvalid = 1'b1;

    //   rst stl red rpc           rv | req addr          vld instr          pc4
    add(0, 0, 0, 32'h0,          1,   0, 32'h0000_0100, 0, NOP,           32'h0000_0104);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0100, 1, 32'hDEAD_0100, 32'h0000_0104);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0104, 1, 32'hDEAD_0104, 32'h0000_0108);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0108, 1, 32'hDEAD_0108, 32'h0000_010C);
    add(1, 0, 0, 32'h0,          0,   1, 32'h0000_010C, 0, NOP,           32'h0000_0110);
    add(1, 0, 0, 32'h0,          0,   1, 32'h0000_010C, 0, NOP,           32'h0000_0110);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_010C, 1, 32'hDEAD_010C, 32'h0000_0110);
    add(1, 0, 0, 32'h0,          0,   1, 32'h0000_0110, 0, NOP,           32'h0000_0114);
    add(1, 0, 0, 32'h0,          0,   1, 32'h0000_0110, 0, NOP,           32'h0000_0114);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0110, 1, 32'hDEAD_0110, 32'h0000_0114);
    add(1, 0, 1, 32'h0000_0200,  1,   1, 32'h0000_0114, 1, 32'hDEAD_0114, 32'h0000_0118);
    add(1, 1, 0, 32'h0,          1,   1, 32'h0000_0200, 1, 32'hDEAD_0200, 32'h0000_0204);
    add(1, 1, 0, 32'h0,          1,   0, 32'h0000_0200, 1, 32'hDEAD_0200, 32'h0000_0204);
    add(1, 1, 0, 32'h0,          1,   0, 32'h0000_0200, 1, 32'hDEAD_0200, 32'h0000_0204);
    add(1, 0, 0, 32'h0,          1,   0, 32'h0000_0200, 1, 32'hDEAD_0200, 32'h0000_0204);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0204, 1, 32'hDEAD_0204, 32'h0000_0208);
    add(1, 0, 1, 32'h0000_0300,  1,   1, 32'h0000_0208, 1, 32'hDEAD_0208, 32'h0000_020C);
    add(1, 0, 0, 32'h0,          0,   1, 32'h0000_0300, 0, NOP,           32'h0000_0304);
    add(1, 0, 1, 32'h0000_0403,  0,   1, 32'h0000_0300, 0, NOP,           32'h0000_0304);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0300, 0, NOP,           32'h0000_0404);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0400, 1, 32'hDEAD_0400, 32'h0000_0404);
    add(1, 0, 1, 32'h0000_0500,  0,   1, 32'h0000_0404, 0, NOP,           32'h0000_0408);
    add(1, 0, 1, 32'h0000_0600,  0,   1, 32'h0000_0404, 0, NOP,           32'h0000_0504);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0404, 0, NOP,           32'h0000_0604);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0600, 1, 32'hDEAD_0600, 32'h0000_0604);
    add(1, 1, 1, 32'hFFFF_FFFE,  1,   1, 32'h0000_0604, 1, 32'hDEAD_0604, 32'h0000_0608);
    add(1, 0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC, 1, 32'h2152_FFFC, 32'h0000_0000);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0000, 1, 32'hDEAD_0000, 32'h0000_0004);
    add(1, 1, 0, 32'h0,          1,   1, 32'h0000_0004, 1, 32'hDEAD_0004, 32'h0000_0008);
    add(1, 1, 1, 32'h0000_0700,  1,   0, 32'h0000_0004, 1, 32'hDEAD_0004, 32'h0000_0008);
    add(1, 0, 0, 32'h0,          0,   1, 32'h0000_0700, 0, NOP,           32'h0000_0704);
    add(0, 0, 0, 32'h0,          1,   0, 32'h0000_0700, 0, NOP,           32'h0000_0704);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0000_0100, 1, 32'hDEAD_0100, 32'h0000_0104);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; stall = vq[i].stall; redirect = vq[i].redir;
      redirect_pc = vq[i].rpc; imem_rvalid = vq[i].rv;
      #1;
      check($sformatf("v%0d_req", i),   {31'h0, imem_req}, {31'h0, vq[i].e_req});
      check($sformatf("v%0d_addr", i),  imem_addr,         vq[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'h0, valid},    {31'h0, vq[i].e_valid});
      check($sformatf("v%0d_instr", i), instr,             vq[i].e_instr);
      check($sformatf("v%0d_pc4", i),   pc4,               vq[i].e_pc4);
    end

    // Randomized phase, starting from a reset the model observes.
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
    @(posedge clk);
    m_pc = RPC; m_held = 1'b0; m_discard = 1'b0; m_held_word = 32'h0;
    m_old_addr = RPC; m_fc = 32'h0; m_wc = 32'h0;

    for (int c = 0; c < 3000; c++) begin
      logic        e_req, e_valid, e_rsp;
      logic [31:0] e_addr, e_instr;
      @(negedge clk);
      rst_n       = ($urandom_range(99) != 0);
      stall       = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(9) == 0);
      redirect_pc = $urandom;
      imem_rvalid = ($urandom_range(4) < 3);
      #1;
      if (!rst_n) begin
        e_req = 1'b0; e_addr = m_pc; e_valid = 1'b0; e_instr = NOP; e_rsp = 1'b0;
      end else if (m_held) begin
        e_req = 1'b0; e_addr = m_pc; e_valid = 1'b1; e_instr = m_held_word; e_rsp = 1'b0;
      end else begin
        e_req   = 1'b1;
        e_addr  = m_discard ? m_old_addr : m_pc;
        e_rsp   = imem_rvalid;
        e_valid = imem_rvalid && !m_discard;
        e_instr = e_valid ? (e_addr ^ KEY) : NOP;
      end
      check("rnd_req",   {31'h0, imem_req}, {31'h0, e_req});
      check("rnd_addr",  imem_addr,         e_addr);
      check("rnd_valid", {31'h0, valid},    {31'h0, e_valid});
      check("rnd_instr", instr,             e_instr);
      check("rnd_pc4",   pc4,               m_pc + 32'd4);
`ifdef IF_PERF_CNT_EN
      check("rnd_fetch_cnt", fetch_cnt, m_fc);
      check("rnd_wait_cnt",  wait_cnt,  m_wc);
`endif
      @(posedge clk);
      if (!rst_n) begin
        m_pc = RPC; m_held = 1'b0; m_discard = 1'b0; m_fc = 32'h0; m_wc = 32'h0;
      end else begin
        if (e_valid && !stall && !redirect) m_fc = m_fc + 32'd1;
        if (!m_held && !e_rsp) m_wc = m_wc + 32'd1;
        if (redirect) begin
          if (!m_held && !e_rsp) begin
            if (!m_discard) m_old_addr = m_pc;
            m_discard = 1'b1;
          end else begin
            m_discard = 1'b0;
          end
          m_held = 1'b0;
          m_pc   = {redirect_pc[31:2], 2'b00};
        end else if (m_held) begin
          if (!stall) begin
            m_held = 1'b0;
            m_pc   = m_pc + 32'd4;
          end
        end else if (m_discard) begin
          if (e_rsp) m_discard = 1'b0;
        end else if (e_rsp) begin
          if (stall) begin
            m_held      = 1'b1;
            m_held_word = e_instr;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
